// File: rtl/riscv_ma_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_ma_ctrl -- load/store memory-access controller
//
// Sits between the execute stage and a simple req/ack data bus. One request
// is accepted at a time. It is translated into a word-aligned bus access with
// byte enables and lane-replicated write data. Load data is extracted from
// the addressed lane, extended, and presented on ld_* for one cycle.
//
// Parameters
//   XLEN  data/address width (only 32 is supported)
//   REGA  destination register index width
//   TMO   bus-ack timeout in cycles, 1..255
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   req_valid / req_ready        request handshake from the execute stage
//   req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd
//                                request fields (size: 00 byte, 01 half, 10 word)
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be / mem_ack, mem_rdata
//                                data bus (address word-aligned, data lane-shifted)
//   ld_valid, ld_data, ld_rd     formatted load result (memfetch/memi/rdi)
//   stall                        pipeline hold
//   fault                        one-cycle pulse on timeout or misalignment trap
//
// Configuration macro
//   RISCV_MA_MISALIGN_TRAP_EN    when defined, misaligned half/word requests go
//                                straight to ERR with no bus access; otherwise
//                                the low address bits are forced to alignment.
// -----------------------------------------------------------------------------
module riscv_ma_ctrl #(
  parameter int XLEN = 32,
  parameter int REGA = 5,
  parameter int TMO  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [REGA-1:0] req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            ld_valid,
  output logic [XLEN-1:0] ld_data,
  output logic [REGA-1:0] ld_rd,
  output logic            stall,
  output logic            fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  state_t          state;
  logic [7:0]      cnt;
  logic [1:0]      off_q;   // byte offset of the access inside the word
  logic [1:0]      size_q;
  logic            uns_q;
  logic [REGA-1:0] rd_q;

  logic [1:0]      eff_off;
  logic            misalign;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_fmt;

  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE) | (req_valid & ~req_ready);

  // Request decode: effective offset, byte enables, replicated write data.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    eff_off    = 2'b00;
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (req_size)
      2'b00: begin
        eff_off    = req_addr[1:0];
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        // A half always lives in one of the two aligned halves of the word.
        eff_off    = {req_addr[1], 1'b0};
        be_next    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        eff_off    = 2'b00;
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
  end

`ifdef RISCV_MA_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) & req_addr[0]) |
                    (req_size[1] & (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Load formatting uses the captured offset/size so it is independent of
  // whatever the execute stage drives after acceptance.
  always_comb begin
    lane   = mem_rdata >> {off_q, 3'b000};
    ld_fmt = mem_rdata;
    case (size_q)
      2'b00:   ld_fmt = uns_q ? {{(XLEN-8){1'b0}}, lane[7:0]}
                              : {{(XLEN-8){lane[7]}}, lane[7:0]};
      2'b01:   ld_fmt = uns_q ? {{(XLEN-16){1'b0}}, lane[15:0]}
                              : {{(XLEN-16){lane[15]}}, lane[15:0]};
      default: ld_fmt = mem_rdata;
    endcase
  end

  // NOTE: the reset branch is asynchronous (in the sensitivity list) so the
  // bus and load outputs drop the instant rst falls, abandoning any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      ld_valid  <= 1'b0;
      ld_data   <= '0;
      ld_rd     <= '0;
      fault     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misalign) begin
              fault <= 1'b1;
              state <= ERR;
            end else begin
              mem_we    <= req_we;
              mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              mem_wdata <= wdata_next;
              mem_be    <= be_next;
              off_q     <= eff_off;
              size_q    <= req_size;
              uns_q     <= req_unsigned;
              rd_q      <= req_rd;
              cnt       <= 8'd0;
              mem_req   <= 1'b1;
              state     <= BUS;
            end
          end
        end

        BUS: begin
          // Ack is checked first so an ack at the timeout count still succeeds.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= IDLE;
            end else begin
              ld_data  <= ld_fmt;
              ld_rd    <= rd_q;
              ld_valid <= 1'b1;
              state    <= RESP;
            end
          end else if (cnt == TMO_C) begin
            mem_req <= 1'b0;
            fault   <= 1'b1;
            state   <= ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        RESP: begin
          ld_valid <= 1'b0;
          state    <= IDLE;
        end

        ERR: begin
          fault <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_ma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_ma_ctrl -- self-checking bench for riscv_ma_ctrl
//
// Directed scenarios followed by random transactions. Expected bus fields and
// load results come from an arithmetic model of the load/store rules (byte
// counts, modulo alignment, multiplication for lane replication, numeric
// sign extension). Inputs change 1 time unit after a rising edge; outputs are
// sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_riscv_ma_ctrl;

  localparam int TMO = 15;

`ifdef RISCV_MA_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd;
  logic        stall;
  logic        fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_ma_ctrl #(.XLEN(32), .REGA(5), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
    .stall(stall), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] w, input int n);
    if (n == 1) return (w % 32'd256) * 32'h0101_0101;
    if (n == 2) return (w % 32'd65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] r, input int n,
                                           input int off, input logic uns);
    longint unsigned span, lane;
    if (n == 4) return r;
    span = 64'd1 << (8 * n);
    lane = (64'(r) >> (8 * off)) % span;
    if (!uns && lane >= span / 2) lane = lane + (64'h1_0000_0000 - span);
    return 32'(lane);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   32'(mem_req),   0);
    check({tag, "_mem_we"},    32'(mem_we),    0);
    check({tag, "_mem_be"},    32'(mem_be),    0);
    check({tag, "_mem_addr"},  mem_addr,       0);
    check({tag, "_mem_wdata"}, mem_wdata,      0);
    check({tag, "_ld_valid"},  32'(ld_valid),  0);
    check({tag, "_ld_data"},   ld_data,        0);
    check({tag, "_ld_rd"},     32'(ld_rd),     0);
    check({tag, "_fault"},     32'(fault),     0);
  endtask

  // One complete transaction. ack_at = BUS-cycle index at which mem_ack is
  // driven (0 = first BUS cycle); negative or > TMO means no ack at all.
  task automatic do_txn(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int ack_at, input logic [31:0] rdata);
    int          n, off;
    bit          trap, timeout;
    logic [31:0] e_addr, e_wdata, e_ld;
    logic [3:0]  e_be;
    n       = nbytes(size);
    off     = ((int'(addr % 32'd4)) / n) * n;
    trap    = TRAP_EN && ((addr % 32'(n)) != 0);
    timeout = (ack_at < 0) || (ack_at > TMO);
    e_addr  = addr - (addr % 32'd4);
    e_be    = 4'(((1 << n) - 1) << off);
    e_wdata = exp_wdata(wdata, n);
    e_ld    = exp_load(rdata, n, off, uns);

    // Acceptance cycle.
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 1);
    check({tag, "_stall_idle"}, 32'(stall), 0);
    step();
    // Scramble the request fields to prove they were captured.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_size = 2'($urandom); req_rd = 5'($urandom);
    #1;

    if (trap) begin
      check({tag, "_trap_fault"}, 32'(fault), 1);
      check({tag, "_trap_memreq"}, 32'(mem_req), 0);
      check({tag, "_trap_ldv"}, 32'(ld_valid), 0);
      step();
      check({tag, "_trap_clear"}, 32'(fault), 0);
      check({tag, "_trap_ready"}, 32'(req_ready), 1);
      return;
    end

    for (int k = 0; k <= TMO; k++) begin
      check({tag, "_bus_req"}, 32'(mem_req), 1);
      check({tag, "_bus_we"}, 32'(mem_we), 32'(we));
      check({tag, "_bus_addr"}, mem_addr, e_addr);
      check({tag, "_bus_be"}, 32'(mem_be), 32'(e_be));
      if (we) check({tag, "_bus_wdata"}, mem_wdata, e_wdata);
      check({tag, "_bus_stall"}, 32'(stall), 1);
      check({tag, "_bus_ldv"}, 32'(ld_valid), 0);
      check({tag, "_bus_fault"}, 32'(fault), 0);
      if (k == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      step();
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1;
      if (k == ack_at) break;
    end

    if (timeout) begin
      check({tag, "_tmo_fault"}, 32'(fault), 1);
      check({tag, "_tmo_memreq"}, 32'(mem_req), 0);
      check({tag, "_tmo_ldv"}, 32'(ld_valid), 0);
      step();
      check({tag, "_tmo_clear"}, 32'(fault), 0);
      check({tag, "_tmo_ready"}, 32'(req_ready), 1);
    end else if (we) begin
      check({tag, "_st_ldv"}, 32'(ld_valid), 0);
      check({tag, "_st_memreq"}, 32'(mem_req), 0);
      check({tag, "_st_ready"}, 32'(req_ready), 1);
      check({tag, "_st_fault"}, 32'(fault), 0);
    end else begin
      check({tag, "_ld_valid"}, 32'(ld_valid), 1);
      check({tag, "_ld_data"}, ld_data, e_ld);
      check({tag, "_ld_rd"}, 32'(ld_rd), 32'(rd));
      check({tag, "_ld_memreq"}, 32'(mem_req), 0);
      check({tag, "_ld_fault"}, 32'(fault), 0);
      step();
      check({tag, "_ld_drop"}, 32'(ld_valid), 0);
      check({tag, "_ld_hold"}, ld_data, e_ld);
      check({tag, "_ld_ready"}, 32'(req_ready), 1);
    end
  endtask

  initial begin
    // Reset state.
    #1;
    check_reset_outputs("rst0");
    step();
    step();
    rst = 1'b1;
    step();
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_stall", 32'(stall), 0);

    // Word / byte / half loads from 0xDEADBEEF, first-cycle ack.
    do_txn("lw100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF);
    do_txn("lb103",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7, 0, 32'hDEADBEEF);
    do_txn("lhu102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd9, 0, 32'hDEADBEEF);

    // Byte store with ack in the fifth BUS cycle.
    do_txn("sb201",  1'b1, 2'b00, 1'b0, 32'h201, 32'h5A, 5'd1, 4, 32'h0);

    // Timeout without ack, then ack exactly at the timeout count.
    do_txn("tmo",    1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd4, -1, 32'h0);
    do_txn("ack15",  1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 5'd5, TMO, 32'h1234_5678);

    // Half load at an odd address.
    do_txn("lh301",  1'b0, 2'b01, 1'b0, 32'h301, 32'h0, 5'd6, 0, 32'h8001_7FFE);

    // mem_ack in IDLE is ignored.
    mem_ack = 1'b1;
    step();
    step();
    check("ack_idle_ldv", 32'(ld_valid), 0);
    check("ack_idle_ready", 32'(req_ready), 1);
    check("ack_idle_memreq", 32'(mem_req), 0);
    mem_ack = 1'b0;
    step();

    // Reset in the second BUS cycle of a load.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h500; req_rd = 5'd11;
    step();
    req_valid = 1'b0;
    #1;
    check("rstbus_req1", 32'(mem_req), 1);
    step();
    check("rstbus_req2", 32'(mem_req), 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rstbus");
    step();
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstbus_no_ldv", 32'(ld_valid), 0);
      check("rstbus_idle", 32'(req_ready), 1);
    end
    mem_ack = 1'b0;

    // Random transactions.
    for (int t = 0; t < 40; t++) begin
      int          r, ack_at;
      logic [1:0]  size;
      r      = int'($urandom_range(9, 0));
      ack_at = (r == 9) ? -1 : (r == 8) ? TMO : r % 6;
      size   = 2'($urandom_range(2, 0));
      do_txn("rnd", 1'($urandom), size, 1'($urandom), $urandom, $urandom,
             5'($urandom), ack_at, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_ma_ctrl.md
RISCV_MA_CTRL -- requirements
Module: riscv_ma_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have parameter REGA, default 5, destination register index width.
REQ-003 SHALL have parameter TMO, default 15, the bus-ack timeout in cycles; legal range 1..255.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, execute stage presents a load/store.
REQ-007 SHALL have port req_ready, output, 1, controller accepts a request this cycle.
REQ-008 SHALL have ports req_we (1, store), req_size (2: 00 byte, 01 half, 10 word), req_unsigned (1), req_addr (XLEN), req_wdata (XLEN), req_rd (REGA), all inputs.
REQ-009 SHALL have outputs mem_req (1), mem_we (1), mem_addr (XLEN, word-aligned), mem_wdata (XLEN, lane-shifted), mem_be (4, byte enables); inputs mem_ack (1) and mem_rdata (XLEN).
REQ-010 SHALL have outputs ld_valid (1), ld_data (XLEN), ld_rd (REGA), which feed the memory-access stage's memfetch, memi and rdi inputs.
REQ-011 SHALL have outputs stall (1, pipeline hold) and fault (1, one-cycle access error pulse).

Function
REQ-012 SHALL implement the states IDLE, BUS, RESP and ERR.
REQ-013 SHALL drive req_ready=1 only in IDLE and SHALL drive stall = (state!=IDLE) | (req_valid & ~req_ready).
REQ-014 SHALL, in IDLE on req_valid=1, capture all req_* fields in one cycle and go to BUS.
REQ-015 SHALL, in BUS, hold mem_req=1 and keep mem_we/addr/wdata/be stable until mem_ack is sampled 1.
REQ-016 SHALL drive mem_req=0 in every state other than BUS.
REQ-017 SHALL form mem_addr = {addr[XLEN-1:2], 2'b00}; mem_be = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word).
REQ-018 SHALL form mem_wdata with the byte/half replicated into every lane, so the lane selected by mem_be holds the data.
REQ-019 SHALL, on mem_ack in BUS, go to IDLE for a store, or register the formatted rdata and go to RESP for a load.
REQ-020 SHALL format load data by extracting the lane at addr[1:0], then zero-extending if req_unsigned else sign-extending; word loads pass unchanged.
REQ-021 SHALL, in RESP, drive ld_valid=1 with ld_data/ld_rd valid for exactly one cycle, then go to IDLE.
REQ-022 SHALL hold ld_valid=0 outside RESP; ld_data/ld_rd SHALL keep their last values.
REQ-023 SHALL count BUS cycles from 0 and, if the count reaches TMO without mem_ack, go to ERR, drop mem_req and abandon the access.
REQ-024 SHALL clear the timeout counter on every entry to BUS.
REQ-025 SHALL, in ERR, pulse fault=1 for one cycle with ld_valid=0, then go to IDLE.
REQ-026 SHALL treat mem_ack in the same cycle the count reaches TMO as success; ack wins over timeout.
REQ-027 SHALL ignore mem_ack outside BUS.
REQ-028 SHALL give a load latency of exactly 3 cycles from acceptance to ld_valid when mem_ack arrives in the first BUS cycle; each later ack adds one cycle.

Reset
REQ-029 SHALL, while rst=0, force state IDLE, counter 0, mem_req/mem_we/mem_be/ld_valid/fault 0, and mem_addr/mem_wdata/ld_data/ld_rd 0.
REQ-030 SHALL abandon an in-flight access on reset assertion and issue no ld_valid for it.
REQ-031 SHALL resume in IDLE from the first rising clk edge after rst returns to 1.

Configuration
REQ-032 SHALL, with macro RISCV_MA_MISALIGN_TRAP_EN defined, send an accepted request whose half has addr[0]=1, or whose word has addr[1:0]!=0, straight from IDLE to ERR, issuing no bus access.
REQ-033 SHALL, without RISCV_MA_MISALIGN_TRAP_EN, force addr[0] to 0 for half accesses and addr[1:0] to 0 for word accesses, and never fault for misalignment.

Verification
REQ-034 SHALL cover: word at mem_rdata=0xDEADBEEF, load word at 0x100 with ack in the first BUS cycle -> mem_be=1111, ld_valid at cycle 3, ld_data=0xDEADBEEF.
REQ-035 SHALL cover: same word, signed byte load at 0x103 -> mem_be=1000, ld_data=0xFFFFFFDE; unsigned half at 0x102 -> ld_data=0x0000DEAD.
REQ-036 SHALL cover: store byte 0x5A at 0x201 with ack delayed 4 cycles -> mem_be=0010, mem_wdata=0x5A5A5A5A, signals stable 5 cycles, stall high throughout, no ld_valid.
REQ-037 SHALL cover: TMO=15, no ack -> fault pulse at BUS count 15, then req_ready=1; repeat with ack at count 15 -> load completes, no fault.
REQ-038 SHALL cover: rst low in the second BUS cycle -> all outputs 0 immediately, no ld_valid after release.
REQ-039 SHALL cover: half load at 0x301 -> with the macro defined, fault and no mem_req; without it, mem_be=0011 at mem_addr 0x300.
